// File: rtl/bram_data_responder.sv
// bram_data_responder: CPU load/store responder over an internal word-wide block RAM
module bram_data_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] SIZE      = 32'h0001_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);
  localparam int AW    = $clog2(SIZE);
  localparam int DEPTH = int'(SIZE >> 2);
  localparam logic [2:0] MEM_LB = 3'd0, MEM_LBU = 3'd1, MEM_LH = 3'd2, MEM_LHU = 3'd3;
  localparam logic [2:0] MEM_LW = 3'd4, MEM_SB = 3'd5, MEM_SH = 3'd6, MEM_SW = 3'd7;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [2:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_word;
  logic [31:0]   off;
  logic          misal, err_nx, store;
  logic [3:0]    be;
  logic [31:0]   wlanes, ld;
  logic [7:0]    rb;
  logic [15:0]   rh;
  assign off    = req_addr - BASE_ADDR;
  assign misal  = ((req_op == MEM_LH || req_op == MEM_LHU || req_op == MEM_SH) && req_addr[0]) ||
                  ((req_op == MEM_LW || req_op == MEM_SW) && req_addr[1:0] != 2'b00);
  assign err_nx = misal || off >= SIZE;
  assign store  = op_q == MEM_SB || op_q == MEM_SH || op_q == MEM_SW;
  assign be     = op_q == MEM_SB ? 4'b0001 << addr_q[1:0] :
                  op_q == MEM_SH ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wlanes = op_q == MEM_SB ? {4{wdata_q[7:0]}} :
                  op_q == MEM_SH ? {2{wdata_q[15:0]}} : wdata_q;
  assign rb = 8'(rd_word >> {addr_q[1:0], 3'b000});
  assign rh = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
  assign ld = op_q == MEM_LB  ? {{24{rb[7]}}, rb}  :
              op_q == MEM_LBU ? {24'd0, rb}        :
              op_q == MEM_LH  ? {{16{rh[15]}}, rh} :
              op_q == MEM_LHU ? {16'd0, rh}        :
              op_q == MEM_LW  ? rd_word            : 32'd0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        err_q   <= err_nx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      rd_word <= mem[addr_q[AW-1:2]];
      for (int i = 0; i < 4; i++)
        if (store && !err_q && be[i]) mem[addr_q[AW-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
    end
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    rsp_error = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q) ? ld : 32'd0;
    state_nx  = (state == IDLE && req_valid) ? ACCESS :
                state == ACCESS              ? RESP   :
                (state == RESP && rsp_ready) ? IDLE   : state;
  end
endmodule

// File: tb/tb_bram_data_responder.sv
// tb_bram_data_responder: directed load/store sequence with a queue of expected responses.
module tb_bram_data_responder;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   typedef struct {logic [31:0] d; logic e;} exp_t;
   exp_t sb[$];
   int n_vec = 0;
   int n_err = 0;

   localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

   bram_data_responder dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic xact(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input int hold);
      int w;
      exp_t e;
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 10) begin @(negedge clk); w++; end
      chk("req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
      sb.push_back('{ed, ee});
      @(negedge clk);
      req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      rsp_ready = (hold == 0);
      w = 0;
      while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("latency", 32'(w), 32'd1);
      if (rsp_valid) begin
         e = sb.pop_front();
         chk($sformatf("rdata op%0d@%h", op, a), rsp_rdata, e.d);
         chk($sformatf("error op%0d@%h", op, a), 32'(rsp_error), 32'(e.e));
         if (hold > 0) begin
            repeat (hold) begin
               @(negedge clk);
               chk("hold_valid", 32'(rsp_valid), 32'd1);
               chk("hold_rdata", rsp_rdata, e.d);
               chk("hold_error", 32'(rsp_error), 32'(e.e));
               chk("hold_req_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("release_valid", 32'(rsp_valid), 32'd0);
            chk("release_req_ready", 32'(req_ready), 32'd1);
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      reset_n = 1'b1;
      // basic word store/load
      xact(SW,  32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0);
      xact(LW,  32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);
      // byte lanes
      xact(SB,  32'h103, 32'hFFFF_FF80, 32'h0, 1'b0, 0);
      xact(LB,  32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 0);
      xact(LBU, 32'h103, 32'h0, 32'h00000080, 1'b0, 0);
      xact(LW,  32'h100, 32'h0, 32'h80ADBEEF, 1'b0, 0);
      xact(LB,  32'h101, 32'h0, 32'hFFFFFFBE, 1'b0, 0);
      // half lanes
      xact(SH,  32'h102, 32'hABCD1234, 32'h0, 1'b0, 0);
      xact(LH,  32'h102, 32'h0, 32'h00001234, 1'b0, 0);
      xact(LHU, 32'h100, 32'h0, 32'h0000BEEF, 1'b0, 0);
      xact(LH,  32'h100, 32'h0, 32'hFFFFBEEF, 1'b0, 0);
      xact(LBU, 32'h102, 32'h0, 32'h00000034, 1'b0, 0);
      // faults
      xact(LH,  32'h101, 32'h0, 32'h0, 1'b1, 0);
      xact(SW,  32'h102, 32'h55555555, 32'h0, 1'b1, 0);
      xact(LW,  32'h00010000, 32'h0, 32'h0, 1'b1, 0);
      xact(SB,  32'h00010100, 32'h77, 32'h0, 1'b1, 0);
      xact(LW,  32'h100, 32'h0, 32'h1234BEEF, 1'b0, 0);
      // last word of window
      xact(SW,  32'hFFFC, 32'hCAFEF00D, 32'h0, 1'b0, 0);
      xact(LW,  32'hFFFC, 32'h0, 32'hCAFEF00D, 1'b0, 0);
      // response back-pressure
      xact(LW,  32'h100, 32'h0, 32'h1234BEEF, 1'b0, 5);
      // reset during ACCESS drops an uncommitted store
      xact(SW,  32'h200, 32'h11223344, 32'h0, 1'b0, 0);
      @(negedge clk);
      req_valid = 1'b1; req_op = SW; req_addr = 32'h200; req_wdata = 32'hA5A5A5A5;
      @(negedge clk);
      req_valid = 1'b0;
      chk("access_req_ready", 32'(req_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      @(negedge clk);
      reset_n = 1'b1;
      xact(LW,  32'h200, 32'h0, 32'h11223344, 1'b0, 0);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
